// File: rtl/tc_sequencer_if.sv
// Sequencer-side bundle: request inputs, ADC and converter handshakes, published result and status.
// master = tc_sequencer, slave = the surrounding front-end / converter / consumer.
`timescale 1ns/1ps
interface tc_sequencer_if;
    logic        i_enable;
    logic        i_trigger;
    logic        i_clear;
    logic        o_adc_start;
    logic        i_adc_valid;
    logic [9:0]  i_adc_code;
    logic        o_calc_start;
    logic [9:0]  o_calc_code;
    logic        i_calc_done;
    logic [19:0] i_calc_temp;
    logic [19:0] o_temp;
    logic        o_temp_valid;
    logic        o_busy;
    logic [2:0]  o_status;

    modport master (
        input  i_enable, i_trigger, i_clear,
        output o_adc_start,
        input  i_adc_valid, i_adc_code,
        output o_calc_start, o_calc_code,
        input  i_calc_done, i_calc_temp,
        output o_temp, o_temp_valid, o_busy, o_status
    );

    modport slave (
        output i_enable, i_trigger, i_clear,
        input  o_adc_start,
        output i_adc_valid, i_adc_code,
        input  o_calc_start, o_calc_code,
        output i_calc_done, i_calc_temp,
        input  o_temp, o_temp_valid, o_busy, o_status
    );
endinterface

// File: rtl/tc_sequencer.sv
// Thermocouple measurement sequencer: tick/trigger -> 2^AVG_LOG2 ADC samples -> average -> converter -> o_temp.
// Latency: request at t gives o_temp_valid at t+2N+1+(ADC and converter wait cycles); t+2N+5 with 1/3-cycle responders.
// Backpressure: none; one request is queued while busy, further ones are dropped and flagged; waits abort after TIMEOUT.
`timescale 1ns/1ps
module tc_sequencer #(
    parameter int SAMPLE_DIV = 1000,
    parameter int AVG_LOG2   = 2,
    parameter int TIMEOUT    = 64
) (
    input  logic           i_clk,
    input  logic           i_rst,
    tc_sequencer_if.master bus
);
    localparam int TW = $clog2(SAMPLE_DIV);
    localparam int WW = $clog2(TIMEOUT);
    localparam int AW = 10 + AVG_LOG2;
    localparam int CW = AVG_LOG2 + 1;
    localparam logic [TW-1:0] TIMER_LAST = TW'(SAMPLE_DIV - 1);
    localparam logic [WW-1:0] WAIT_LAST  = WW'(TIMEOUT - 1);
    localparam logic [CW-1:0] SAMP_LAST  = CW'((1 << AVG_LOG2) - 1);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        ADC_REQ   = 3'd1,
        ADC_WAIT  = 3'd2,
        CALC_REQ  = 3'd3,
        CALC_WAIT = 3'd4
    } state_t;

    state_t          state_q, state_d;
    logic [TW-1:0]   timer_q;
    logic            tick;
    logic            req;
    logic            pending_q;
    logic            overrun;
    logic [AW-1:0]   acc_q;
    logic [AW-1:0]   acc_sum;
    logic [CW-1:0]   samp_q;
    logic [WW-1:0]   wait_q;
    logic            start_meas;
    logic            take_sample;
    logic            last_sample;
    logic            adc_to;
    logic            calc_to;
    logic            calc_ok;

    assign tick    = bus.i_enable && (timer_q == TIMER_LAST);
    assign req     = tick || bus.i_trigger;
    assign overrun = req && (state_q != IDLE) && pending_q;
    // Accumulator is wide enough for 2^AVG_LOG2 full-scale codes, so this never wraps.
    assign acc_sum = acc_q + AW'(bus.i_adc_code);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        start_meas  = 1'b0;
        take_sample = 1'b0;
        last_sample = 1'b0;
        adc_to      = 1'b0;
        calc_to     = 1'b0;
        calc_ok     = 1'b0;
        case (state_q)
            IDLE: begin
                if (req || pending_q) begin
                    start_meas = 1'b1;
                    state_d    = ADC_REQ;
                end
            end
            ADC_REQ: state_d = ADC_WAIT;
            ADC_WAIT: begin
                if (bus.i_adc_valid) begin
                    take_sample = 1'b1;
                    if (samp_q == SAMP_LAST) begin
                        last_sample = 1'b1;
                        state_d     = CALC_REQ;
                    end else begin
                        state_d = ADC_REQ;
                    end
                end else if (wait_q == WAIT_LAST) begin
                    adc_to  = 1'b1;
                    state_d = IDLE;
                end
            end
            CALC_REQ: state_d = CALC_WAIT;
            CALC_WAIT: begin
                if (bus.i_calc_done) begin
                    calc_ok = 1'b1;
                    state_d = IDLE;
                end else if (wait_q == WAIT_LAST) begin
                    calc_to = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        bus.o_adc_start  = 1'b0;
        bus.o_calc_start = 1'b0;
        bus.o_busy       = 1'b1;
        case (state_q)
            IDLE:     bus.o_busy       = 1'b0;
            ADC_REQ:  bus.o_adc_start  = 1'b1;
            CALC_REQ: bus.o_calc_start = 1'b1;
            default:  bus.o_busy       = 1'b1;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            timer_q          <= '0;
            pending_q        <= 1'b0;
            acc_q            <= '0;
            samp_q           <= '0;
            wait_q           <= '0;
            bus.o_calc_code  <= '0;
            bus.o_temp       <= '0;
            bus.o_temp_valid <= 1'b0;
            bus.o_status     <= '0;
        end else begin
            if (!bus.i_enable || tick) begin
                timer_q <= '0;
            end else begin
                timer_q <= timer_q + TW'(1);
            end

            // In IDLE any request (or the held one) is consumed by start_meas this cycle.
            if (state_q == IDLE) begin
                pending_q <= 1'b0;
            end else if (req) begin
                pending_q <= 1'b1;
            end

            if (start_meas) begin
                acc_q  <= '0;
                samp_q <= '0;
            end else if (take_sample) begin
                acc_q  <= acc_sum;
                samp_q <= samp_q + CW'(1);
            end

            if (state_q == ADC_WAIT || state_q == CALC_WAIT) begin
                wait_q <= wait_q + WW'(1);
            end else begin
                wait_q <= '0;
            end

            if (last_sample) begin
                bus.o_calc_code <= acc_sum[AVG_LOG2 +: 10];
            end

            if (calc_ok) begin
                bus.o_temp <= bus.i_calc_temp;
            end
            bus.o_temp_valid <= calc_ok;

            // Events raised in the same cycle as i_clear survive it.
            bus.o_status <= (bus.i_clear ? 3'b000 : bus.o_status) | {overrun, calc_to, adc_to};
        end
    end
endmodule

// File: tb/tb_tc_sequencer.sv
// Bench for tc_sequencer: ADC/converter responders, expected results queued at stimulus time, checked by a monitor.
`timescale 1ns/1ps
module tb_tc_sequencer;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    tc_sequencer_if bus();

    tc_sequencer #(.SAMPLE_DIV(50), .AVG_LOG2(2), .TIMEOUT(16)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    typedef struct {
        logic [19:0] temp;
        int          vcyc;
    } exp_t;

    logic [9:0]  adc_q[$];
    logic [19:0] calc_q[$];
    logic [9:0]  exp_code_q[$];
    exp_t        exp_temp_q[$];

    int   checks  = 0;
    int   errors  = 0;
    int   cyc     = 0;
    int   adc_cnt = 0;
    int   late_at = -1;
    logic adc_mute  = 1'b0;
    logic calc_mute = 1'b0;
    logic adc_pend  = 1'b0;
    int   cd        = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ADC model: valid with the next queued code one cycle after each start.
    always @(negedge clk) begin
        bus.i_adc_valid = 1'b0;
        if (adc_pend) begin
            bus.i_adc_valid = 1'b1;
            bus.i_adc_code  = 10'd0;
            if (adc_q.size() > 0) bus.i_adc_code = adc_q.pop_front();
            adc_pend = 1'b0;
        end
        if (bus.o_adc_start === 1'b1 && !adc_mute) adc_pend = 1'b1;
    end

    // Converter model: done three cycles after its start cycle.
    always @(negedge clk) begin
        bus.i_calc_done = 1'b0;
        if (cyc == late_at) begin
            bus.i_calc_done = 1'b1;
            bus.i_calc_temp = 20'd999;
        end else if (cd > 0) begin
            cd--;
            if (cd == 0) begin
                bus.i_calc_done = 1'b1;
                bus.i_calc_temp = 20'd0;
                if (calc_q.size() > 0) bus.i_calc_temp = calc_q.pop_front();
            end
        end
        if (bus.o_calc_start === 1'b1 && !calc_mute) cd = 3;
    end

    always @(negedge clk) begin
        exp_t e;
        if (bus.o_adc_start === 1'b1) adc_cnt++;
        if (bus.o_calc_start === 1'b1) begin
            if (exp_code_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL calc_start: unexpected start at cycle %0d, code %0d", cyc, bus.o_calc_code);
            end else begin
                chk("calc_code", bus.o_calc_code, exp_code_q.pop_front());
            end
        end
        if (bus.o_temp_valid === 1'b1) begin
            if (exp_temp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL temp_valid: unexpected strobe at cycle %0d, temp %0d", cyc, bus.o_temp);
            end else begin
                e = exp_temp_q.pop_front();
                chk("o_temp", bus.o_temp, e.temp);
                if (e.vcyc >= 0) chk("valid_cycle", cyc, e.vcyc);
            end
        end
    end

    task automatic cyc_n(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_trig();
        bus.i_trigger = 1'b1;
        @(negedge clk);
        bus.i_trigger = 1'b0;
    endtask

    task automatic push_meas(input logic [9:0] c0, input logic [9:0] c1, input logic [9:0] c2,
                             input logic [9:0] c3, input logic [9:0] exp_code,
                             input logic with_temp, input logic [19:0] temp, input int vcyc);
        exp_t e;
        adc_q.push_back(c0);
        adc_q.push_back(c1);
        adc_q.push_back(c2);
        adc_q.push_back(c3);
        exp_code_q.push_back(exp_code);
        if (with_temp) begin
            calc_q.push_back(temp);
            e.temp = temp;
            e.vcyc = vcyc;
            exp_temp_q.push_back(e);
        end
    endtask

    task automatic wait_idle(input int maxc);
        int n = 0;
        while (bus.o_busy !== 1'b0 && n < maxc) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (bus.o_busy !== 1'b0) begin
            errors++;
            $display("FAIL wait_idle: still busy after %0d cycles", maxc);
        end
    endtask

    task automatic wait_start(input int maxc, output int c);
        int n = 0;
        c = -1;
        while (c < 0 && n < maxc) begin
            @(negedge clk);
            n++;
            if (bus.o_adc_start === 1'b1) c = cyc;
        end
        checks++;
        if (c < 0) begin
            errors++;
            $display("FAIL wait_start: no adc_start within %0d cycles", maxc);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int t, e, c1, c2, snap;
        rst           = 1'b1;
        bus.i_enable  = 1'b0;
        bus.i_trigger = 1'b0;
        bus.i_clear   = 1'b0;
        cyc_n(3);
        chk("rst_temp", bus.o_temp, 0);
        chk("rst_calc_code", bus.o_calc_code, 0);
        chk("rst_status", bus.o_status, 0);
        chk("rst_adc_start", bus.o_adc_start, 0);
        chk("rst_calc_start", bus.o_calc_start, 0);
        chk("rst_temp_valid", bus.o_temp_valid, 0);
        chk("rst_busy", bus.o_busy, 0);
        rst = 1'b0;
        cyc_n(2);

        // Nominal: 4 x 300, converter 40000, strobe at t+13
        t = cyc;
        push_meas(10'd300, 10'd300, 10'd300, 10'd300, 10'd300, 1'b1, 20'd40000, t + 13);
        pulse_trig();
        cyc_n(11);
        chk("busy_t12", bus.o_busy, 1);
        chk("valid_t12", bus.o_temp_valid, 0);
        cyc_n(1);
        chk("busy_t13", bus.o_busy, 0);
        chk("nominal_temp", bus.o_temp, 20'd40000);
        cyc_n(3);

        // Truncating average and full-scale codes
        t = cyc;
        push_meas(10'd1, 10'd2, 10'd2, 10'd2, 10'd1, 1'b1, 20'd123, t + 13);
        pulse_trig();
        wait_idle(30);
        cyc_n(3);
        t = cyc;
        push_meas(10'd1023, 10'd1023, 10'd1023, 10'd1023, 10'd1023, 1'b1, 20'hFFFFF, t + 13);
        pulse_trig();
        wait_idle(30);
        chk("fullscale_code", bus.o_calc_code, 10'd1023);
        cyc_n(3);

        // Periodic ticks every 50 cycles; dropping enable lets the in-flight one finish
        e = cyc;
        push_meas(10'd10, 10'd20, 10'd30, 10'd40, 10'd25, 1'b1, 20'd500, e + 62);
        push_meas(10'd5, 10'd5, 10'd5, 10'd6, 10'd5, 1'b1, 20'd777, e + 112);
        bus.i_enable = 1'b1;
        wait_start(60, c1);
        chk("tick1_cycle", c1, e + 50);
        wait_idle(30);
        wait_start(60, c2);
        chk("tick_period", c2 - c1, 50);
        bus.i_enable = 1'b0;
        wait_idle(30);
        snap = adc_cnt;
        cyc_n(120);
        chk("no_ticks_disabled", adc_cnt, snap);

        // Converter timeout
        calc_mute = 1'b1;
        push_meas(10'd8, 10'd8, 10'd8, 10'd8, 10'd8, 1'b0, 20'd0, -1);
        pulse_trig();
        wait_idle(40);
        chk("calc_to_status", bus.o_status, 3'b010);
        chk("calc_to_temp", bus.o_temp, 20'd777);
        calc_mute = 1'b0;
        cyc_n(2);

        // ADC timeout after 16 wait cycles, with i_clear landing on the abort cycle
        adc_mute = 1'b1;
        pulse_trig();
        cyc_n(15);
        chk("adc_to_status_t16", bus.o_status, 3'b010);
        chk("adc_to_busy_t16", bus.o_busy, 1);
        cyc_n(1);
        bus.i_clear = 1'b1;
        cyc_n(1);
        bus.i_clear = 1'b0;
        chk("adc_to_status", bus.o_status, 3'b001);
        chk("adc_to_busy", bus.o_busy, 0);
        chk("adc_to_temp", bus.o_temp, 20'd777);
        bus.i_clear = 1'b1;
        cyc_n(1);
        bus.i_clear = 1'b0;
        chk("clear_status", bus.o_status, 3'b000);
        adc_mute = 1'b0;
        cyc_n(2);

        // Overrun: three extra triggers while busy -> one follow-on, status[2]
        t = cyc;
        snap = adc_cnt;
        push_meas(10'd100, 10'd100, 10'd100, 10'd100, 10'd100, 1'b1, 20'd1000, t + 13);
        push_meas(10'd7, 10'd7, 10'd7, 10'd7, 10'd7, 1'b1, 20'd2000, t + 26);
        pulse_trig();
        cyc_n(2);
        pulse_trig();
        cyc_n(1);
        pulse_trig();
        cyc_n(1);
        pulse_trig();
        cyc_n(30);
        chk("overrun_status", bus.o_status, 3'b100);
        chk("overrun_adc_starts", adc_cnt - snap, 8);
        chk("overrun_idle", bus.o_busy, 0);
        cyc_n(2);

        // Reset during CALC_WAIT; a late done must be ignored
        calc_mute = 1'b1;
        push_meas(10'd50, 10'd50, 10'd50, 10'd50, 10'd50, 1'b0, 20'd0, -1);
        pulse_trig();
        cyc_n(10);
        chk("pre_rst_busy", bus.o_busy, 1);
        rst = 1'b1;
        cyc_n(1);
        chk("mid_rst_temp", bus.o_temp, 0);
        chk("mid_rst_calc_code", bus.o_calc_code, 0);
        chk("mid_rst_status", bus.o_status, 0);
        chk("mid_rst_busy", bus.o_busy, 0);
        chk("mid_rst_temp_valid", bus.o_temp_valid, 0);
        chk("mid_rst_calc_start", bus.o_calc_start, 0);
        rst = 1'b0;
        late_at = cyc + 1;
        cyc_n(4);
        chk("late_done_temp", bus.o_temp, 0);
        chk("late_done_busy", bus.o_busy, 0);
        calc_mute = 1'b0;

        chk("exp_code_left", exp_code_q.size(), 0);
        chk("exp_temp_left", exp_temp_q.size(), 0);
        chk("adc_codes_left", adc_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
